// File: rtl/lcd_cmd_writer.sv
// HD44780 8-bit write-only command/data writer with E-pulse and execution-wait timing,
// driven by the Start/EN/Ready/Cycend handshake; tracks cursor column and inserts line-wrap addressing.
module lcd_cmd_writer #(
    parameter int unsigned E_CYCLES   = 12,
    parameter int unsigned SHORT_WAIT = 2000,
    parameter int unsigned LONG_WAIT  = 82000,
    parameter logic [7:0]  ENHE_CODE  = 8'h00
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       EN,
    input  logic       Init,
    input  logic       creaenhe,
    input  logic [2:0] scrinit,
    input  logic [7:0] char_in,
    output logic       Ready,
    output logic       Cycend,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic [4:0] col
);

    localparam int unsigned MAX_A = (E_CYCLES > SHORT_WAIT) ? E_CYCLES : SHORT_WAIT;
    localparam int unsigned MAX_C = (MAX_A > LONG_WAIT) ? MAX_A : LONG_WAIT;
    localparam int unsigned CW    = $clog2(MAX_C + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EHIGH,
        S_WAIT,
        S_DONE,
        S_END
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          ready_n, cycend_n, rs_n, e_n;
    logic [7:0]    db_n;
    logic [4:0]    col_n;
    logic          wrap, wrap_n;
    logic          long_w, long_n;
    logic          pend, pend_n;
    logic [7:0]    pend_db, pend_db_n;
    logic [7:0]    data_byte;

    assign lcd_rw    = 1'b0;
    assign data_byte = creaenhe ? ENHE_CODE : char_in;

    always_ff @(posedge clk) begin
        if (Reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            Ready   <= 1'b0;
            Cycend  <= 1'b0;
            lcd_rs  <= 1'b0;
            lcd_e   <= 1'b0;
            lcd_db  <= '0;
            col     <= '0;
            wrap    <= 1'b0;
            long_w  <= 1'b0;
            pend    <= 1'b0;
            pend_db <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            Ready   <= ready_n;
            Cycend  <= cycend_n;
            lcd_rs  <= rs_n;
            lcd_e   <= e_n;
            lcd_db  <= db_n;
            col     <= col_n;
            wrap    <= wrap_n;
            long_w  <= long_n;
            pend    <= pend_n;
            pend_db <= pend_db_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        ready_n   = Ready;
        cycend_n  = 1'b0;
        rs_n      = lcd_rs;
        e_n       = lcd_e;
        db_n      = lcd_db;
        col_n     = col;
        wrap_n    = wrap;
        long_n    = long_w;
        pend_n    = pend;
        pend_db_n = pend_db;

        case (state)
            S_IDLE: begin
                ready_n = 1'b0;
                e_n     = 1'b0;
                if (Start && EN) begin
                    state_n = S_SETUP;
                    long_n  = 1'b0;
                    pend_n  = 1'b0;
                    rs_n    = 1'b0;
                    case (scrinit)
                        3'b101: db_n = 8'h38;
                        3'b010: db_n = 8'h06;
                        3'b011: db_n = 8'h0C;
                        3'b001: begin
                            db_n   = 8'h01;
                            long_n = 1'b1;
                            col_n  = '0;
                            wrap_n = 1'b0;
                        end
                        3'b100: begin
                            db_n   = 8'h80;
                            col_n  = '0;
                            wrap_n = 1'b0;
                        end
                        3'b110: begin
                            // A wrap address command goes first; the data byte waits in pend_db.
                            if (col == 5'd16) begin
                                db_n      = 8'hC0;
                                pend_n    = 1'b1;
                                pend_db_n = data_byte;
                            end else if (col == 5'd0 && wrap) begin
                                db_n      = 8'h80;
                                pend_n    = 1'b1;
                                pend_db_n = data_byte;
                                wrap_n    = 1'b0;
                            end else begin
                                db_n = data_byte;
                                rs_n = 1'b1;
                            end
                        end
                        3'b000: begin
                            if (Init) begin
                                db_n   = 8'h01;
                                long_n = 1'b1;
                                col_n  = '0;
                                wrap_n = 1'b0;
                            end else begin
                                state_n = S_DONE;
                                ready_n = 1'b1;
                                rs_n    = lcd_rs;
                            end
                        end
                        default: begin
                            state_n = S_DONE;
                            ready_n = 1'b1;
                            rs_n    = lcd_rs;
                        end
                    endcase
                end
            end
            S_SETUP: begin
                state_n = S_EHIGH;
                e_n     = 1'b1;
                cnt_n   = CW'(E_CYCLES - 1);
            end
            S_EHIGH: begin
                if (cnt == '0) begin
                    state_n = S_WAIT;
                    e_n     = 1'b0;
                    cnt_n   = long_w ? CW'(LONG_WAIT - 1) : CW'(SHORT_WAIT - 1);
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    if (lcd_rs) begin
                        col_n = col + 5'd1;
                        if (col == 5'd31)
                            wrap_n = 1'b1;
                    end
                    if (pend) begin
                        state_n = S_SETUP;
                        db_n    = pend_db;
                        rs_n    = 1'b1;
                        pend_n  = 1'b0;
                        long_n  = 1'b0;
                    end else begin
                        state_n = S_DONE;
                        ready_n = 1'b1;
                    end
                end
            end
            S_DONE: begin
                ready_n = 1'b1;
                if (!EN) begin
                    state_n  = S_END;
                    cycend_n = 1'b1;
                end
            end
            S_END: begin
                state_n = S_IDLE;
                ready_n = 1'b0;
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lcd_cmd_writer.sv
// Scoreboard bench for lcd_cmd_writer: expected LCD bus bytes are queued by the driver
// and checked by a monitor on every lcd_e pulse; handshake latency is checked by the driver.
module tb_lcd_cmd_writer;

    localparam int unsigned EC = 2;
    localparam int unsigned SW = 4;
    localparam int unsigned LW = 10;

    logic       clk = 1'b0;
    logic       Reset, Start, EN, Init, creaenhe;
    logic [2:0] scrinit;
    logic [7:0] char_in;
    logic       Ready, Cycend, lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;
    logic [4:0] col;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    lcd_cmd_writer #(
        .E_CYCLES  (EC),
        .SHORT_WAIT(SW),
        .LONG_WAIT (LW),
        .ENHE_CODE (8'h00)
    ) dut (
        .clk     (clk),
        .Reset   (Reset),
        .Start   (Start),
        .EN      (EN),
        .Init    (Init),
        .creaenhe(creaenhe),
        .scrinit (scrinit),
        .char_in (char_in),
        .Ready   (Ready),
        .Cycend  (Cycend),
        .lcd_rs  (lcd_rs),
        .lcd_rw  (lcd_rw),
        .lcd_e   (lcd_e),
        .lcd_db  (lcd_db),
        .col     (col)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each lcd_e rising edge consumes one expected {rs,db}.
    logic prev_e = 1'b0;
    int   hcnt   = 0;
    int   cur    = 0;
    always @(negedge clk) begin
        if (Reset) begin
            prev_e = 1'b0;
            hcnt   = 0;
        end else begin
            if (lcd_e) begin
                if (!prev_e) begin
                    hcnt = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        cur = -1;
                        $display("FAIL unexpected_byte: got 0x%0h expected none", {lcd_rs, lcd_db});
                    end else begin
                        cur = exp_q.pop_front();
                    end
                end
                hcnt++;
                if (cur >= 0)
                    chk("bus_byte", {23'd0, lcd_rs, lcd_db}, cur);
            end else if (prev_e) begin
                chk("e_width", hcnt, EC);
            end
            prev_e = lcd_e;
        end
    end

    task automatic do_op(input logic [2:0] sel, input logic init, input logic enhe,
                         input logic [7:0] ch, input int lat, input int hold);
        int n = 0;
        @(negedge clk);
        scrinit  = sel;
        Init     = init;
        creaenhe = enhe;
        char_in  = ch;
        Start    = 1'b1;
        EN       = 1'b1;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) Start = 1'b0;
        end while (!Ready && n < 400);
        chk("latency", n, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_state", {29'd0, Ready, Cycend, lcd_e}, 3'b100);
        end
        EN = 1'b0;
        @(negedge clk);
        chk("cycend_pulse", {30'd0, Ready, Cycend}, 2'b11);
        @(negedge clk);
        chk("back_idle", {30'd0, Ready, Cycend}, 2'b00);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; EN = 1'b0; Init = 1'b0; creaenhe = 1'b0;
        scrinit = 3'b000; char_in = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {Ready, Cycend, lcd_rs, lcd_rw, lcd_e, lcd_db, col}, 0);
        Reset = 1'b0;

        // Function set: 1 + 2 + 4 + 1
        exp_q.push_back(9'h038);
        do_op(3'b101, 1'b0, 1'b0, 8'h00, 8, 0);

        // Clear via Init: 1 + 2 + 10 + 1
        exp_q.push_back(9'h001);
        do_op(3'b000, 1'b1, 1'b0, 8'h00, 14, 0);
        chk("col_after_clear", col, 0);

        // No-op selects go straight to DONE
        do_op(3'b111, 1'b0, 1'b0, 8'h00, 1, 0);
        do_op(3'b000, 1'b0, 1'b0, 8'h00, 1, 0);
        exp_q.push_back(9'h006);
        do_op(3'b010, 1'b0, 1'b0, 8'h00, 8, 0);
        exp_q.push_back(9'h00C);
        do_op(3'b011, 1'b0, 1'b0, 8'h00, 8, 0);

        // Home then 17 chars; the 17th is preceded by 0xC0 (two bytes: 15 cycles)
        exp_q.push_back(9'h080);
        do_op(3'b100, 1'b0, 1'b0, 8'h00, 8, 0);
        for (int i = 1; i <= 17; i++) begin
            if (i == 17) exp_q.push_back(9'h0C0);
            exp_q.push_back(9'h141);
            do_op(3'b110, 1'b0, 1'b0, 8'h41, (i == 17) ? 15 : 8, 0);
        end
        chk("col_after_17", col, 17);

        // Special character replaces char_in
        exp_q.push_back(9'h100);
        do_op(3'b110, 1'b0, 1'b1, 8'h55, 8, 0);
        chk("col_after_enhe", col, 18);

        // Run to column 31 and past; next write re-addresses with 0x80
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(9'h142);
            do_op(3'b110, 1'b0, 1'b0, 8'h42, 8, 0);
        end
        chk("col_wrapped", col, 0);
        exp_q.push_back(9'h080);
        exp_q.push_back(9'h143);
        do_op(3'b110, 1'b0, 1'b0, 8'h43, 15, 0);
        chk("col_after_rewrap", col, 1);

        // Reset in the middle of the E pulse
        exp_q.push_back(9'h038);
        @(negedge clk);
        scrinit = 3'b101; Start = 1'b1; EN = 1'b1;
        begin
            int n = 0;
            while (!lcd_e && n < 20) begin
                @(negedge clk);
                n++;
                Start = 1'b0;
            end
            chk("e_seen_before_reset", lcd_e, 1);
        end
        @(negedge clk);
        Reset = 1'b1;
        EN    = 1'b0;
        @(negedge clk);
        chk("reset_abort", {Ready, Cycend, lcd_e, col}, 0);
        @(negedge clk);
        Reset = 1'b0;
        exp_q.push_back(9'h038);
        do_op(3'b101, 1'b0, 1'b0, 8'h00, 8, 0);

        // EN held in DONE for 20 cycles
        exp_q.push_back(9'h00C);
        do_op(3'b011, 1'b0, 1'b0, 8'h00, 8, 20);

        repeat (5) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
